tree_path_tracker: RTL and testbench
====================================

// Module: tree_path_tracker
// PURPOSE
//  Tracks the current position in the message-hierarchy tree as nested message
//  identifiers stream in: push on enter, pop on exit. After each operation it
//  resolves the active path against a runtime-programmable dependency table and
//  returns the matching message index and node_data.
//  Sits between the field/tag decoder and the per-message field handlers.
//  Generalises the fixed 2-level/2-message constant tables to parameterised
//  depth, entry count and widths, with a writable table.
// PARAMETERS
//  NUM_LEVELS  2  max hierarchy depth (stack entries)
//  NUM_MSGS    2  dependency-table entries
//  ID_W        8  identifier width; id 0 is reserved as "unused level"
//  NODE_W      1  node_data width
// PORTS
//  clk            in   1                    clock
//  rst_n          in   1                    async active-low reset
//  in_valid       in   1                    op request valid
//  in_ready       out  1                    op accepted when valid&ready
//  in_op          in   2                    00 PUSH, 01 POP, 10 CLEAR, 11 QUERY
//  in_id          in   ID_W                 identifier for PUSH (ignored otherwise)
//  out_valid      out  1                    result valid
//  out_ready      in   1                    result consumed when valid&ready
//  out_hit        out  1                    active path matched a table entry
//  out_msg_idx    out  $clog2(NUM_MSGS)     matching entry index (0 if no hit)
//  out_node_data  out  NODE_W               node_data of entry (0 if no hit)
//  out_depth      out  $clog2(NUM_LEVELS+1) depth after the op
//  out_err        out  1                    overflow, underflow or PUSH of id 0
//  cfg_we         in   1                    table write strobe
//  cfg_addr       in   $clog2(NUM_MSGS)     entry to write
//  cfg_path       in   NUM_LEVELS*ID_W      path; level0 in bits [ID_W-1:0], unused levels 0
//  cfg_node_data  in   NODE_W               node_data for entry
//  cfg_en         in   1                    entry valid bit written with the entry
// BEHAVIOUR
//  - Reset: all outputs 0; depth 0; stack all 0; all table entries invalid and zeroed.
//  - Output is a single register stage: in_ready = !out_valid | out_ready.
//    An op accepted in cycle N produces its result in N+1. With out_ready held low,
//    out_* stays stable and in_ready stays low.
//  - PUSH: if id==0 or depth==NUM_LEVELS, set err=1 and leave state unchanged.
//    Otherwise stack[depth]<=id and depth++.
//  - POP: if depth==0, set err=1. Otherwise depth-- and the popped level is cleared to 0.
//  - CLEAR: depth<=0 and stack zeroed. Result hit=0, err=0.
//  - QUERY: no state change; re-resolve the current path.
//  - Resolution: compute the post-op path (levels>=depth read as 0) combinationally in
//    the accept cycle. Compare it against all valid entries in parallel over all
//    NUM_LEVELS levels. Lowest matching index wins. Depth 0 never hits.
//    On err, hit=0 and out_depth is the unchanged depth.
//  - cfg write in the same cycle as an accepted op: the op resolves against the OLD
//    entry. The new entry takes effect for ops accepted from the next cycle.
//    Writes are always accepted and ignore the handshake.
//  - cfg_addr >= NUM_MSGS: write is ignored.
//  - Reset asserted mid-operation: pending result dropped (out_valid=0), stack and
//    table cleared.
// STRUCTURE
//  - tree_pkg holds: op_e enum, identifier_t (logic[ID_W-1:0]), path_t
//    (identifier_t[NUM_LEVELS-1:0]), node_data_t, and the default table constants
//    used by benches.
//  - One sub-module: tree_path_matcher, purely combinational. Inputs: path plus table
//    (paths, valid bits, node_data). Outputs: hit, idx, node_data, via a priority
//    encoder. Parameterised on NUM_LEVELS, NUM_MSGS, ID_W, NODE_W.
// TESTING
//  1. Program e0={00,AA}->0 and e1={BB,AA}->1. PUSH AA -> hit=1, idx=0, data=0,
//     depth=1. PUSH BB -> hit=1, idx=1, data=1, depth=2.
//  2. At depth 2, PUSH CC -> err=1, depth=2. POP -> idx=0, depth=1. POP -> hit=0,
//     depth=0. POP -> err=1, depth=0.
//  3. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable.
//     Release -> queued op completes the next cycle with no loss or duplication.
//  4. PUSH 00 -> err=1, state unchanged. Then PUSH AA, PUSH DD -> hit=0, depth=2.
//     Then CLEAR -> depth=0, hit=0.
//  5. cfg write e1={BB,AA}->0 in the same cycle as QUERY at path {BB,AA} -> data=1.
//     Next QUERY -> data=0.
//  6. Assert rst_n low mid-stream with out_valid=1 -> all outputs 0 immediately.
//     After release, PUSH AA -> hit=0 (table cleared).

Source files
------------

// File: rtl/tree_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tree_pkg                                                      |
// | Brief    : Shared types and default dependency-table contents for the    |
// |            message-hierarchy path tracker.                               |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
package tree_pkg;

    localparam int unsigned c_def_num_levels = 2;
    localparam int unsigned c_def_num_msgs   = 2;
    localparam int unsigned c_def_id_w       = 8;
    localparam int unsigned c_def_node_w     = 1;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_QUERY = 2'b11
    } op_e;

    typedef logic [c_def_id_w-1:0]                identifier_t;
    typedef identifier_t [c_def_num_levels-1:0]   path_t;
    typedef logic [c_def_node_w-1:0]              node_data_t;

    // Default table: level 0 sits in the low identifier slot
    localparam path_t      c_def_path_e0 = {8'h00, 8'hAA};
    localparam node_data_t c_def_node_e0 = 1'b0;
    localparam path_t      c_def_path_e1 = {8'hBB, 8'hAA};
    localparam node_data_t c_def_node_e1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tree_path_matcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tree_path_matcher                                             |
// | Brief    : Combinational lookup of a path against every valid table      |
// |            entry; lowest matching index wins.                            |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tree_path_matcher #(
    parameter  int unsigned NUM_LEVELS = 2,
    parameter  int unsigned NUM_MSGS   = 2,
    parameter  int unsigned ID_W       = 8,
    parameter  int unsigned NODE_W     = 1,
    localparam int unsigned PATH_W     = NUM_LEVELS * ID_W,
    localparam int unsigned IDX_W      = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
    input  logic                       i_en,
    input  logic [PATH_W-1:0]          i_path,
    input  logic [NUM_MSGS*PATH_W-1:0] i_tbl_path,
    input  logic [NUM_MSGS-1:0]        i_tbl_valid,
    input  logic [NUM_MSGS*NODE_W-1:0] i_tbl_node,
    output logic                       o_hit,
    output logic [IDX_W-1:0]           o_idx,
    output logic [NODE_W-1:0]          o_node_data
);

    logic [NUM_MSGS*NUM_LEVELS-1:0] w_lvl_eq;
    logic [NUM_MSGS-1:0]            w_match;

    generate
        for (genvar e = 0; e < NUM_MSGS; e++) begin : g_entry
            for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_level
                assign w_lvl_eq[e*NUM_LEVELS + l] =
                    (i_tbl_path[e*PATH_W + l*ID_W +: ID_W] == i_path[l*ID_W +: ID_W]);
            end
            // Every level must agree, including the zero-filled unused ones
            assign w_match[e] = i_en & i_tbl_valid[e] & (&w_lvl_eq[e*NUM_LEVELS +: NUM_LEVELS]);
        end
    endgenerate

    // Priority encoder: scan from the top so the lowest index is written last
    always_comb begin
        o_hit       = 1'b0;
        o_idx       = '0;
        o_node_data = '0;
        for (int i = NUM_MSGS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit       = 1'b1;
                o_idx       = IDX_W'(i);
                o_node_data = i_tbl_node[i*NODE_W +: NODE_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tree_path_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tree_path_tracker                                             |
// | Brief    : Identifier stack for the message hierarchy with a writable    |
// |            dependency table; resolves the active path after each op.     |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tree_path_tracker
    import tree_pkg::*;
#(
    parameter  int unsigned NUM_LEVELS = 2,
    parameter  int unsigned NUM_MSGS   = 2,
    parameter  int unsigned ID_W       = 8,
    parameter  int unsigned NODE_W     = 1,
    localparam int unsigned PATH_W     = NUM_LEVELS * ID_W,
    localparam int unsigned IDX_W      = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
    localparam int unsigned DEPTH_W    = $clog2(NUM_LEVELS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [ID_W-1:0]    in_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_hit,
    output logic [IDX_W-1:0]   out_msg_idx,
    output logic [NODE_W-1:0]  out_node_data,
    output logic [DEPTH_W-1:0] out_depth,
    output logic               out_err,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [PATH_W-1:0]  cfg_path,
    input  logic [NODE_W-1:0]  cfg_node_data,
    input  logic               cfg_en
);

    localparam logic [DEPTH_W-1:0] c_full  = DEPTH_W'(NUM_LEVELS);
    localparam logic [DEPTH_W-1:0] c_one   = DEPTH_W'(1);

    // Stack and depth
    logic [PATH_W-1:0]  r_stack;
    logic [DEPTH_W-1:0] r_depth;

    // Dependency table
    logic [NUM_MSGS*PATH_W-1:0] r_tbl_path;
    logic [NUM_MSGS-1:0]        r_tbl_valid;
    logic [NUM_MSGS*NODE_W-1:0] r_tbl_node;

    // Result register stage
    logic               r_out_valid;
    logic               r_out_hit;
    logic [IDX_W-1:0]   r_out_idx;
    logic [NODE_W-1:0]  r_out_node;
    logic [DEPTH_W-1:0] r_out_depth;
    logic               r_out_err;

    // Accept-cycle combinational state
    op_e                w_op;
    logic               w_accept;
    logic               w_err;
    logic [PATH_W-1:0]  w_next_stack;
    logic [DEPTH_W-1:0] w_next_depth;
    logic [PATH_W-1:0]  w_resolve_path;
    logic               w_match_en;
    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic [NODE_W-1:0]  w_node;

    assign w_op     = op_e'(in_op);
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Next stack/depth for the requested op; errors leave state untouched
    always_comb begin
        w_next_stack = r_stack;
        w_next_depth = r_depth;
        w_err        = 1'b0;
        case (w_op)
            OP_PUSH: begin
                if ((in_id == '0) || (r_depth == c_full)) begin
                    w_err = 1'b1;
                end else begin
                    for (int l = 0; l < NUM_LEVELS; l++) begin
                        if (DEPTH_W'(l) == r_depth) begin
                            w_next_stack[l*ID_W +: ID_W] = in_id;
                        end
                    end
                    w_next_depth = r_depth + c_one;
                end
            end
            OP_POP: begin
                if (r_depth == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_next_depth = r_depth - c_one;
                    for (int l = 0; l < NUM_LEVELS; l++) begin
                        if (DEPTH_W'(l) == w_next_depth) begin
                            w_next_stack[l*ID_W +: ID_W] = '0;
                        end
                    end
                end
            end
            OP_CLEAR: begin
                w_next_stack = '0;
                w_next_depth = '0;
            end
            default: begin
                // QUERY re-resolves the current path without changing it
            end
        endcase
    end

    // Post-op path with levels at or above the new depth forced to zero
    always_comb begin
        w_resolve_path = '0;
        for (int l = 0; l < NUM_LEVELS; l++) begin
            if (DEPTH_W'(l) < w_next_depth) begin
                w_resolve_path[l*ID_W +: ID_W] = w_next_stack[l*ID_W +: ID_W];
            end
        end
    end

    // An empty path or a rejected op never reports a hit
    assign w_match_en = !w_err && (w_next_depth != '0);

    tree_path_matcher #(
        .NUM_LEVELS (NUM_LEVELS),
        .NUM_MSGS   (NUM_MSGS),
        .ID_W       (ID_W),
        .NODE_W     (NODE_W)
    ) u_matcher (
        .i_en        (w_match_en),
        .i_path      (w_resolve_path),
        .i_tbl_path  (r_tbl_path),
        .i_tbl_valid (r_tbl_valid),
        .i_tbl_node  (r_tbl_node),
        .o_hit       (w_hit),
        .o_idx       (w_idx),
        .o_node_data (w_node)
    );

    // Commit stack and depth when an op is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stack <= '0;
            r_depth <= '0;
        end else if (w_accept) begin
            r_stack <= w_next_stack;
            r_depth <= w_next_depth;
        end
    end

    // Table writes bypass the handshake; an op in the same cycle sees the old entry
    generate
        for (genvar e = 0; e < NUM_MSGS; e++) begin : g_tbl
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tbl_path[e*PATH_W +: PATH_W] <= '0;
                    r_tbl_node[e*NODE_W +: NODE_W] <= '0;
                    r_tbl_valid[e]                 <= 1'b0;
                end else if (cfg_we && (cfg_addr == IDX_W'(e))) begin
                    r_tbl_path[e*PATH_W +: PATH_W] <= cfg_path;
                    r_tbl_node[e*NODE_W +: NODE_W] <= cfg_node_data;
                    r_tbl_valid[e]                 <= cfg_en;
                end
            end
        end
    endgenerate

    // Single-entry result buffer: load on accept, drain when consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_idx   <= '0;
            r_out_node  <= '0;
            r_out_depth <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_hit   <= w_hit;
            r_out_idx   <= w_idx;
            r_out_node  <= w_node;
            r_out_depth <= w_next_depth;
            r_out_err   <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_hit       = r_out_hit;
    assign out_msg_idx   = r_out_idx;
    assign out_node_data = r_out_node;
    assign out_depth     = r_out_depth;
    assign out_err       = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_tree_path_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tree_path_tracker                                          |
// | Brief    : Directed self-checking bench for tree_path_tracker.           |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_tree_path_tracker;
    import tree_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    identifier_t in_id;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [0:0]  out_msg_idx;
    node_data_t  out_node_data;
    logic [1:0]  out_depth;
    logic        out_err;
    logic        cfg_we;
    logic [0:0]  cfg_addr;
    path_t       cfg_path;
    node_data_t  cfg_node_data;
    logic        cfg_en;

    int n_checks = 0;
    int n_err    = 0;

    tree_path_tracker #(
        .NUM_LEVELS (c_def_num_levels),
        .NUM_MSGS   (c_def_num_msgs),
        .ID_W       (c_def_id_w),
        .NODE_W     (c_def_node_w)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_id         (in_id),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_hit       (out_hit),
        .out_msg_idx   (out_msg_idx),
        .out_node_data (out_node_data),
        .out_depth     (out_depth),
        .out_err       (out_err),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_path      (cfg_path),
        .cfg_node_data (cfg_node_data),
        .cfg_en        (cfg_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] v, input logic [31:0] hit,
                             input logic [31:0] idx, input logic [31:0] data,
                             input logic [31:0] depth, input logic [31:0] err);
        check({tag, ".valid"}, 32'(out_valid), v);
        check({tag, ".hit"},   32'(out_hit), hit);
        check({tag, ".idx"},   32'(out_msg_idx), idx);
        check({tag, ".data"},  32'(out_node_data), data);
        check({tag, ".depth"}, 32'(out_depth), depth);
        check({tag, ".err"},   32'(out_err), err);
    endtask

    // Issue one op from a negedge; result is sampled 1 time unit after the accepting edge
    task automatic do_op(input op_e op, input identifier_t id, input logic [31:0] hit,
                         input logic [31:0] idx, input logic [31:0] data,
                         input logic [31:0] depth, input logic [31:0] err, input string tag);
        in_valid = 1'b1;
        in_op    = op;
        in_id    = id;
        #1;
        check({tag, ".rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check_out(tag, 32'd1, hit, idx, data, depth, err);
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_op         = 2'b00;
        in_id         = '0;
        out_ready     = 1'b1;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_path      = '0;
        cfg_node_data = '0;
        cfg_en        = 1'b0;

        repeat (2) @(negedge clk);
        check_out("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Program e0={00,AA}->0, e1={BB,AA}->1
        cfg_we = 1'b1; cfg_en = 1'b1;
        cfg_addr = 1'b0; cfg_path = c_def_path_e0; cfg_node_data = c_def_node_e0;
        @(negedge clk);
        cfg_addr = 1'b1; cfg_path = c_def_path_e1; cfg_node_data = c_def_node_e1;
        @(negedge clk);
        cfg_we = 1'b0;

        do_op(OP_PUSH, 8'hAA, 1, 0, 0, 1, 0, "t1.push_aa");
        do_op(OP_PUSH, 8'hBB, 1, 1, 1, 2, 0, "t1.push_bb");

        do_op(OP_PUSH, 8'hCC, 0, 0, 0, 2, 1, "t2.push_ovf");
        do_op(OP_POP,  8'h00, 1, 0, 0, 1, 0, "t2.pop1");
        do_op(OP_POP,  8'h00, 0, 0, 0, 0, 0, "t2.pop2");
        do_op(OP_POP,  8'h00, 0, 0, 0, 0, 1, "t2.pop_unf");

        // Backpressure: result of PUSH AA held while PUSH BB waits
        do_op(OP_PUSH, 8'hAA, 1, 0, 0, 1, 0, "t3.push_aa");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_PUSH;
        in_id     = 8'hBB;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("t3.stall.rdy", 32'(in_ready), 32'd0);
            check_out("t3.stall", 1, 1, 0, 0, 1, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("t3.release.rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_out("t3.release", 1, 1, 1, 1, 2, 0);
        @(posedge clk);
        #1;
        check("t3.no_dup", 32'(out_valid), 32'd0);
        @(negedge clk);
        do_op(OP_QUERY, 8'h00, 1, 1, 1, 2, 0, "t3.query");
        do_op(OP_CLEAR, 8'h00, 0, 0, 0, 0, 0, "t3.clear");

        do_op(OP_PUSH,  8'h00, 0, 0, 0, 0, 1, "t4.push_zero");
        do_op(OP_PUSH,  8'hAA, 1, 0, 0, 1, 0, "t4.push_aa");
        do_op(OP_PUSH,  8'hDD, 0, 0, 0, 2, 0, "t4.push_dd");
        do_op(OP_CLEAR, 8'h00, 0, 0, 0, 0, 0, "t4.clear");

        // Table rewrite racing a QUERY: old entry used, new one from next op
        do_op(OP_PUSH, 8'hAA, 1, 0, 0, 1, 0, "t5.push_aa");
        do_op(OP_PUSH, 8'hBB, 1, 1, 1, 2, 0, "t5.push_bb");
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_path = c_def_path_e1;
        cfg_node_data = 1'b0; cfg_en = 1'b1;
        do_op(OP_QUERY, 8'h00, 1, 1, 1, 2, 0, "t5.query_old");
        do_op(OP_QUERY, 8'h00, 1, 1, 0, 2, 0, "t5.query_new");

        // Reset with a pending result
        do_op(OP_CLEAR, 8'h00, 0, 0, 0, 0, 0, "t6.clear");
        do_op(OP_PUSH,  8'hAA, 1, 0, 0, 1, 0, "t6.push_aa");
        out_ready = 1'b0;
        #2;
        check("t6.pending", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_out("t6.reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        do_op(OP_PUSH, 8'hAA, 0, 0, 0, 1, 0, "t6.push_aa_after");
        do_op(OP_PUSH, 8'hBB, 0, 0, 0, 2, 0, "t6.push_bb_after");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
